fifo_flow_ctrl_fsm: RTL and testbench
=====================================

# fifo_flow_ctrl_fsm

Parametrised top-level flow-control state machine for the multi-FIFO datapath. It supervises N_FIFO FIFOs, captures per-FIFO almost-full/almost-empty thresholds during initialisation, reports idle/active status with a configurable idle hold-off, and latches FIFO errors until software clears them. It sits beside the FIFO array and drives the threshold configuration inputs of every FIFO.

## Interface
- N_FIFO, 5: number of supervised FIFOs.
- TH_W, 2: width of one threshold field.
- IDLE_HOLD, 1: consecutive all-empty cycles in ACTIVE before moving to IDLE; must be at least 1.
- ERR_CNT_W, 8: width of the error-entry counter.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  request configuration (INIT) state.
- err_clr  in  1  clear latched errors and leave ERROR.
- fifo_err  in  N_FIFO  per-FIFO error flags.
- fifo_empty  in  N_FIFO  per-FIFO empty flags.
- af_th_i  in  N_FIFO*TH_W  almost-full thresholds; FIFO k at bits [k*TH_W +: TH_W].
- ae_th_i  in  N_FIFO*TH_W  almost-empty thresholds; same packing.
- af_th_o  out  N_FIFO*TH_W  captured almost-full thresholds.
- ae_th_o  out  N_FIFO*TH_W  captured almost-empty thresholds.
- error_o  out  N_FIFO  sticky latched error vector.
- active_o  out  1  high while in ACTIVE.
- idle_o  out  1  high while in IDLE.
- state_o  out  5  one-hot current state.
- err_cnt_o  out  ERR_CNT_W  count of ERROR entries.

## Operation
- States, one-hot: RESET, INIT, IDLE, ACTIVE, ERROR.
- RESET: always goes to INIT next cycle.
- INIT: stays while init=1; otherwise goes to IDLE. af_th_o and ae_th_o load from af_th_i and ae_th_i on every clock edge while in INIT. They hold in all other states. fifo_err is ignored.
- IDLE and ACTIVE priority, highest first:
  - Any fifo_err bit set: go to ERROR; error_o <= fifo_err.
  - init=1: go to INIT.
  - Otherwise evaluate the empty flags.
- IDLE: any fifo_empty bit low goes to ACTIVE; otherwise stay in IDLE.
- ACTIVE: an internal idle counter increments on each all-empty cycle and resets on any non-empty cycle. When the all-empty cycle reaches a count of IDLE_HOLD, go to IDLE and zero the counter. IDLE_HOLD=1 means immediate exit. The counter also zeroes on leaving ACTIVE for any reason.
- ERROR:
  - error_o <= error_o | fifo_err, so errors accumulate.
  - init is ignored.
  - err_clr=1: go to INIT and clear error_o to 0. Clear wins over a same-cycle new error.
- Illegal or non-one-hot state: recover to RESET next cycle.
- Outputs are decoded from registered state and registers only; there are no combinational input-to-output paths.

## Timing
- reset=1 at an edge forces the following, from the next cycle: state RESET, state_o=5'b00001, all other outputs 0, idle counter 0, err_cnt_o 0. This applies at any point, including mid-ACTIVE or in ERROR.
- Input-to-status latency is 1 cycle. A condition sampled at edge n is visible on outputs after edge n.
- error_o and state_o=ERROR become visible in the same cycle.
- From reset deassertion, the earliest IDLE is 2 cycles later (RESET, INIT, IDLE) when init=0.
- Thresholds captured on the last INIT cycle remain valid from the first IDLE cycle.

## Configuration
- FIFO_FLOW_ERR_CNT_EN defined:
  - err_cnt_o increments on every transition into ERROR.
  - It saturates at 2^ERR_CNT_W-1.
  - It is cleared only by reset, not by err_clr.
- Not defined: err_cnt_o is tied to 0 and no counter logic is synthesised. The port list is unchanged.

## Structure
- Shared package fifo_flow_pkg holds:
  - one-hot state localparams ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR;
  - default values for N_FIFO, TH_W and ERR_CNT_W.
- One sub-module, fifo_flow_idle_timer: parametrised by IDLE_HOLD; inputs all_empty, enable, clear; output hold_done.

## Test plan
- Reset, then init=1 for 3 cycles with af_th_i=10'h2AA and ae_th_i=10'h155, then init=0 -> af_th_o=10'h2AA and ae_th_o=10'h155 persist, idle_o=1 one cycle after init drops, later threshold changes are ignored.
- IDLE, fifo_empty=5'b11011 -> active_o=1 next cycle. With IDLE_HOLD=4: 3 all-empty cycles then one non-empty cycle -> stays ACTIVE; 4 all-empty cycles -> idle_o=1 on the following cycle.
- ACTIVE, fifo_err=5'b00100 -> error_o=5'b00100 and state_o=ERROR. Then fifo_err=5'b00001 -> error_o=5'b00101. Then err_clr=1 -> INIT next cycle with error_o=0.
- ACTIVE with init=1 and fifo_err=5'b10000 in the same cycle -> ERROR, not INIT. In ERROR, init=1 -> stays in ERROR.
- reset=1 mid-ACTIVE and in ERROR -> next cycle state_o=5'b00001, error_o=0, thresholds 0, active_o=idle_o=0.
- FIFO_FLOW_ERR_CNT_EN with ERR_CNT_W=2: 5 error/clear sequences -> err_cnt_o=3, saturated. Without the macro -> err_cnt_o=0 throughout.

Source files
------------

// File: rtl/fifo_flow_pkg.sv
// ============================================================================
// Module      : fifo_flow_pkg
// Description : Shared one-hot state encodings, state type and default
//               parameter values for the FIFO flow-control supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_flow_pkg;

  // One-hot state encodings
  localparam logic [4:0] ST_RESET  = 5'b00001;
  localparam logic [4:0] ST_INIT   = 5'b00010;
  localparam logic [4:0] ST_IDLE   = 5'b00100;
  localparam logic [4:0] ST_ACTIVE = 5'b01000;
  localparam logic [4:0] ST_ERROR  = 5'b10000;

  // Default parameter values
  localparam int DEF_N_FIFO    = 5;
  localparam int DEF_TH_W      = 2;
  localparam int DEF_ERR_CNT_W = 8;

  typedef enum logic [4:0] {
    S_RESET  = ST_RESET,
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_ERROR  = ST_ERROR
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_flow_idle_timer.sv
// ============================================================================
// Module      : fifo_flow_idle_timer
// Description : Counts consecutive all-empty cycles while enabled; hold_done
//               flags the cycle whose all-empty sample reaches IDLE_HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flow_idle_timer #(
  parameter int IDLE_HOLD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic all_empty,
  input  logic enable,
  input  logic clear,
  output logic hold_done
);

  localparam int CNT_W = $clog2(IDLE_HOLD + 1);

  logic [CNT_W-1:0] count;

  // Current all-empty sample completes the run of IDLE_HOLD cycles
  assign hold_done = enable && all_empty && (count == CNT_W'(IDLE_HOLD - 1));

  // Run-length counter; zero whenever disabled, cleared or interrupted
  always_ff @(posedge clk) begin
    if (reset || !enable || clear || hold_done || !all_empty) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_flow_ctrl_fsm.sv
// ============================================================================
// Module      : fifo_flow_ctrl_fsm
// Description : Flow-control supervisor for N_FIFO FIFOs: threshold capture in
//               INIT, idle/active status with idle hold-off, sticky error
//               latching until err_clr.
//               Optional macro FIFO_FLOW_ERR_CNT_EN enables the saturating
//               count of ERROR entries (otherwise err_cnt_o is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flow_ctrl_fsm
  import fifo_flow_pkg::*;
#(
  parameter int N_FIFO    = DEF_N_FIFO,
  parameter int TH_W      = DEF_TH_W,
  parameter int IDLE_HOLD = 1,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   err_clr,
  input  logic [N_FIFO-1:0]      fifo_err,
  input  logic [N_FIFO-1:0]      fifo_empty,
  input  logic [N_FIFO*TH_W-1:0] af_th_i,
  input  logic [N_FIFO*TH_W-1:0] ae_th_i,
  output logic [N_FIFO*TH_W-1:0] af_th_o,
  output logic [N_FIFO*TH_W-1:0] ae_th_o,
  output logic [N_FIFO-1:0]      error_o,
  output logic                   active_o,
  output logic                   idle_o,
  output logic [4:0]             state_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  state_t state, state_nxt;
  logic   load_th, err_load, err_acc, err_clear;
  logic   tmr_en, tmr_clear, hold_done;
  logic   any_err, all_empty;

  assign any_err   = |fifo_err;
  assign all_empty = &fifo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else       state <= state_nxt;
  end

  // Next-state logic and register-update strobes
  always_comb begin
    state_nxt = state;
    load_th   = 1'b0;
    err_load  = 1'b0;
    err_acc   = 1'b0;
    err_clear = 1'b0;
    case (state)
      S_RESET: state_nxt = S_INIT;
      S_INIT: begin
        load_th = 1'b1;
        if (!init) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (any_err) begin
          state_nxt = S_ERROR;
          err_load  = 1'b1;
        end else if (init) begin
          state_nxt = S_INIT;
        end else if (!all_empty) begin
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (any_err) begin
          state_nxt = S_ERROR;
          err_load  = 1'b1;
        end else if (init) begin
          state_nxt = S_INIT;
        end else if (hold_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        // Clear takes priority over a same-cycle new error
        if (err_clr) begin
          state_nxt = S_INIT;
          err_clear = 1'b1;
        end else begin
          err_acc = 1'b1;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  assign tmr_en    = (state == S_ACTIVE);
  assign tmr_clear = tmr_en && (state_nxt != S_ACTIVE);

  fifo_flow_idle_timer #(
    .IDLE_HOLD (IDLE_HOLD)
  ) u_idle_timer (
    .clk       (clk),
    .reset     (reset),
    .all_empty (all_empty),
    .enable    (tmr_en),
    .clear     (tmr_clear),
    .hold_done (hold_done)
  );

  // Threshold capture while in INIT, hold elsewhere
  always_ff @(posedge clk) begin
    if (reset) begin
      af_th_o <= '0;
      ae_th_o <= '0;
    end else if (load_th) begin
      af_th_o <= af_th_i;
      ae_th_o <= ae_th_i;
    end
  end

  // Sticky error vector: load on entry, accumulate in ERROR, clear on err_clr
  always_ff @(posedge clk) begin
    if (reset || err_clear) error_o <= '0;
    else if (err_load)      error_o <= fifo_err;
    else if (err_acc)       error_o <= error_o | fifo_err;
  end

`ifdef FIFO_FLOW_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 enter_err;

  assign enter_err = (state_nxt == S_ERROR) && (state != S_ERROR);

  // Saturating count of ERROR entries; err_clr does not touch it
  always_ff @(posedge clk) begin
    if (reset)                              err_cnt <= '0;
    else if (enter_err && (err_cnt != '1))  err_cnt <= err_cnt + ERR_CNT_W'(1);
  end

  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  assign state_o  = state;
  assign active_o = (state == S_ACTIVE);
  assign idle_o   = (state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_flow_ctrl_fsm.sv
// ============================================================================
// Module      : tb_fifo_flow_ctrl_fsm
// Description : Directed plus random stimulus for fifo_flow_ctrl_fsm, every
//               cycle compared against a behavioural model of the supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_flow_ctrl_fsm;

  localparam int N    = 5;
  localparam int TH   = 2;
  localparam int HOLD = 4;
  localparam int ECW  = 2;
  localparam int W    = N * TH;
  localparam int ERR_MAX = (1 << ECW) - 1;

  // Model modes, bit position of the one-hot state_o
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  logic          clk = 1'b0;
  logic          reset, init, err_clr;
  logic [N-1:0]  fifo_err, fifo_empty;
  logic [W-1:0]  af_in, ae_in, af_out, ae_out;
  logic [N-1:0]  error_o;
  logic          active_o, idle_o;
  logic [4:0]    state_o;
  logic [ECW-1:0] err_cnt_o;

  fifo_flow_ctrl_fsm #(
    .N_FIFO    (N),
    .TH_W      (TH),
    .IDLE_HOLD (HOLD),
    .ERR_CNT_W (ECW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .err_clr    (err_clr),
    .fifo_err   (fifo_err),
    .fifo_empty (fifo_empty),
    .af_th_i    (af_in),
    .ae_th_i    (ae_in),
    .af_th_o    (af_out),
    .ae_th_o    (ae_out),
    .error_o    (error_o),
    .active_o   (active_o),
    .idle_o     (idle_o),
    .state_o    (state_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  int           m_mode = M_RESET;
  int           m_run  = 0;
  int           m_cnt  = 0;
  logic [W-1:0] m_af   = '0;
  logic [W-1:0] m_ae   = '0;
  logic [N-1:0] m_err  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic enter_error();
    m_mode = M_ERROR;
`ifdef FIFO_FLOW_ERR_CNT_EN
    if (m_cnt < ERR_MAX) m_cnt++;
`endif
  endtask

  // Apply the supervisor's rules to the inputs sampled at this edge
  task automatic model_step();
    if (reset) begin
      m_mode = M_RESET; m_run = 0; m_cnt = 0;
      m_af = '0; m_ae = '0; m_err = '0;
      return;
    end
    case (m_mode)
      M_RESET: m_mode = M_INIT;
      M_INIT: begin
        m_af = af_in; m_ae = ae_in;
        if (!init) m_mode = M_IDLE;
      end
      M_IDLE: begin
        if (fifo_err != 0)          begin m_err = fifo_err; enter_error(); end
        else if (init)              m_mode = M_INIT;
        else if (fifo_empty != '1)  m_mode = M_ACTIVE;
      end
      M_ACTIVE: begin
        if (fifo_err != 0)      begin m_err = fifo_err; enter_error(); m_run = 0; end
        else if (init)          begin m_mode = M_INIT; m_run = 0; end
        else if (fifo_empty == '1) begin
          m_run++;
          if (m_run == HOLD) begin m_mode = M_IDLE; m_run = 0; end
        end else m_run = 0;
      end
      default: begin
        if (err_clr) begin m_mode = M_INIT; m_err = '0; end
        else m_err = m_err | fifo_err;
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("state_o",   32'(state_o),   32'(1 << m_mode));
    chk("active_o",  32'(active_o),  32'(m_mode == M_ACTIVE));
    chk("idle_o",    32'(idle_o),    32'(m_mode == M_IDLE));
    chk("error_o",   32'(error_o),   32'(m_err));
    chk("af_th_o",   32'(af_out),    32'(m_af));
    chk("ae_th_o",   32'(ae_out),    32'(m_ae));
    chk("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt));
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; err_clr = 1'b0;
    fifo_err = '0; fifo_empty = '1; af_in = '0; ae_in = '0;
    cycle(); cycle();
    chk("reset_state", 32'(state_o), 32'h01);

    // Threshold capture during INIT
    reset = 1'b0; init = 1'b1; af_in = 10'h2AA; ae_in = 10'h155;
    repeat (3) cycle();
    init = 1'b0;
    cycle();
    chk("idle_after_init", 32'(idle_o), 32'h1);
    chk("af_captured",     32'(af_out), 32'h2AA);
    af_in = '0; ae_in = 10'h3FF;
    cycle();
    chk("af_held", 32'(af_out), 32'h2AA);
    chk("ae_held", 32'(ae_out), 32'h155);

    // IDLE -> ACTIVE, idle hold-off
    fifo_empty = 5'b11011; cycle();
    chk("goes_active", 32'(active_o), 32'h1);
    fifo_empty = '1; repeat (3) cycle();
    fifo_empty = 5'b01111; cycle();
    chk("run_broken", 32'(active_o), 32'h1);
    fifo_empty = '1; repeat (3) cycle();
    chk("still_active", 32'(active_o), 32'h1);
    cycle();
    chk("idle_after_hold", 32'(idle_o), 32'h1);

    // Error latch, accumulate, clear
    fifo_empty = 5'b11011; cycle();
    fifo_err = 5'b00100; cycle();
    chk("err_first", 32'(error_o), 32'h04);
    chk("err_state", 32'(state_o), 32'h10);
    fifo_err = 5'b00001; cycle();
    chk("err_accum", 32'(error_o), 32'h05);
    fifo_err = '0; err_clr = 1'b1; cycle();
    chk("clr_to_init", 32'(state_o), 32'h02);
    chk("clr_error",   32'(error_o), 32'h00);
    err_clr = 1'b0; cycle();

    // Error beats init; init ignored in ERROR
    fifo_empty = 5'b11011; cycle();
    init = 1'b1; fifo_err = 5'b10000; cycle();
    chk("err_over_init", 32'(state_o), 32'h10);
    fifo_err = '0; cycle();
    chk("init_ignored", 32'(state_o), 32'h10);
    init = 1'b0;

    // Reset in ERROR and mid-ACTIVE
    reset = 1'b1; cycle();
    chk("rst_err_state", 32'(state_o), 32'h01);
    reset = 1'b0; cycle(); cycle();
    fifo_empty = 5'b11011; cycle();
    reset = 1'b1; cycle();
    chk("rst_act_state", 32'(state_o), 32'h01);
    reset = 1'b0; fifo_empty = '1; cycle(); cycle();

    // Repeated error/clear sequences for the entry counter
    for (int i = 0; i < 5; i++) begin
      fifo_err = 5'b00010; cycle();
      fifo_err = '0; err_clr = 1'b1; cycle();
      err_clr = 1'b0; cycle();
    end
`ifdef FIFO_FLOW_ERR_CNT_EN
    chk("err_cnt_sat", 32'(err_cnt_o), 32'(ERR_MAX));
`else
    chk("err_cnt_off", 32'(err_cnt_o), 32'h0);
`endif

    // Random phase
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 149) == 0);
      init       = ($urandom_range(0, 24) == 0);
      err_clr    = ($urandom_range(0, 5) == 0);
      fifo_err   = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
      fifo_empty = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
      af_in      = W'($urandom);
      ae_in      = W'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
